// File: rtl/player_defense_if.sv
// Player/enemy interface bundle between the game logic and the defense controller.
// master: the side that drives the enemy strobe and player controls and watches the results.
// slave : the defense controller.
// Signals:
//   attack_in, enemy_lane          enemy attack strobe and lane (3 = invalid)
//   dodge_left, dodge_right        dodge levels (rising edge = one move)
//   block_in, punch                block level, punch level (rising edge = one punch)
//   player_lane, player_health,    player state
//   enemy_health                   enemy state
//   hit_taken, dodge_ok,           one-cycle result pulses
//   punch_landed
//   game_over, player_won          sticky end-of-game flags
interface player_defense_if;
  logic       attack_in;
  logic [1:0] enemy_lane;
  logic       dodge_left;
  logic       dodge_right;
  logic       block_in;
  logic       punch;
  logic [1:0] player_lane;
  logic [3:0] player_health;
  logic [3:0] enemy_health;
  logic       hit_taken;
  logic       dodge_ok;
  logic       punch_landed;
  logic       game_over;
  logic       player_won;

  modport master (
    output attack_in, enemy_lane, dodge_left, dodge_right, block_in, punch,
    input  player_lane, player_health, enemy_health, hit_taken, dodge_ok,
           punch_landed, game_over, player_won
  );

  modport slave (
    input  attack_in, enemy_lane, dodge_left, dodge_right, block_in, punch,
    output player_lane, player_health, enemy_health, hit_taken, dodge_ok,
           punch_landed, game_over, player_won
  );
endinterface

// File: rtl/player_defense_ctrl.sv
// Player defense controller: runs the dodge/block window for each enemy attack,
// resolves it against the player lane, tracks both health bars, converts punches
// into enemy damage and raises the sticky game-over flags.
// Ports:
//   clock    system clock
//   reset_n  asynchronous active-low reset
//   bus      player_defense_if.slave (see the interface file for signal list)
// Optional build macro: PLAYER_COUNTER_EN -- one punch in RECOVER after a successful
//   dodge deals 2 damage to the enemy.
module player_defense_ctrl #(
  parameter int WINDOW_CYCLES  = 25_000_000,
  parameter int RECOVER_CYCLES = 12_500_000,
  parameter int CW             = 28,
  parameter int PLAYER_MAX     = 10,
  parameter int ENEMY_MAX      = 15
) (
  input  logic             clock,
  input  logic             reset_n,
  player_defense_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WINDUP, S_RESOLVE, S_RECOVER, S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_atk_lane;
  logic [1:0]    r_lane;
  logic [3:0]    r_ph;
  logic [3:0]    r_eh;
  logic          r_hit;
  logic          r_dodge;
  logic          r_punch_ok;
  logic          r_go;
  logic          r_won;
  logic          r_left_q;
  logic          r_right_q;
  logic          r_punch_q;
`ifdef PLAYER_COUNTER_EN
  logic          r_armed;     // one counter-punch allowed in this recovery
  logic [3:0]    w_eh_dec2;
`endif

  logic       w_left_edge;
  logic       w_right_edge;
  logic       w_punch_edge;
  logic       w_attack_ok;
  logic [1:0] w_lane_nxt;
  logic [3:0] w_dmg;
  logic [3:0] w_ph_hit;
  logic [3:0] w_eh_dec1;

  assign w_left_edge  = bus.dodge_left  & ~r_left_q;
  assign w_right_edge = bus.dodge_right & ~r_right_q;
  assign w_punch_edge = bus.punch       & ~r_punch_q;
  assign w_attack_ok  = bus.attack_in && (bus.enemy_lane != 2'd3);

  // Simultaneous left/right edges cancel; moves saturate at lanes 0 and 2.
  always_comb begin
    w_lane_nxt = r_lane;
    if (w_left_edge && !w_right_edge && r_lane != 2'd0)
      w_lane_nxt = r_lane - 2'd1;
    else if (w_right_edge && !w_left_edge && r_lane != 2'd2)
      w_lane_nxt = r_lane + 2'd1;
  end

  assign w_dmg     = bus.block_in ? 4'd1 : 4'd2;
  assign w_ph_hit  = (r_ph > w_dmg) ? (r_ph - w_dmg) : 4'd0;
  assign w_eh_dec1 = (r_eh != 4'd0) ? (r_eh - 4'd1) : 4'd0;
`ifdef PLAYER_COUNTER_EN
  assign w_eh_dec2 = (r_eh > 4'd2) ? (r_eh - 4'd2) : 4'd0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_atk_lane <= 2'd0;
      r_lane     <= 2'd1;
      r_ph       <= 4'(PLAYER_MAX);
      r_eh       <= 4'(ENEMY_MAX);
      r_hit      <= 1'b0;
      r_dodge    <= 1'b0;
      r_punch_ok <= 1'b0;
      r_go       <= 1'b0;
      r_won      <= 1'b0;
      r_left_q   <= 1'b0;
      r_right_q  <= 1'b0;
      r_punch_q  <= 1'b0;
`ifdef PLAYER_COUNTER_EN
      r_armed    <= 1'b0;
`endif
    end else begin
      r_left_q   <= bus.dodge_left;
      r_right_q  <= bus.dodge_right;
      r_punch_q  <= bus.punch;
      r_hit      <= 1'b0;
      r_dodge    <= 1'b0;
      r_punch_ok <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_lane <= w_lane_nxt;
          // A valid attack takes priority over a punch edge in the same cycle.
          if (w_attack_ok) begin
            r_atk_lane <= bus.enemy_lane;
            r_cnt      <= CW'(WINDOW_CYCLES - 1);
            r_state    <= S_WINDUP;
          end else if (w_punch_edge && r_lane == 2'd1) begin
            r_eh       <= w_eh_dec1;
            r_punch_ok <= 1'b1;
            if (w_eh_dec1 == 4'd0) begin
              r_state <= S_DONE;
              r_go    <= 1'b1;
              r_won   <= 1'b1;
            end
          end
        end
        S_WINDUP: begin
          r_lane <= w_lane_nxt;
          if (r_cnt == '0) r_state <= S_RESOLVE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_RESOLVE: begin
          r_cnt <= CW'(RECOVER_CYCLES - 1);
          if (r_atk_lane == r_lane) begin
            r_ph  <= w_ph_hit;
            r_hit <= 1'b1;
            if (w_ph_hit == 4'd0) begin
              r_state <= S_DONE;
              r_go    <= 1'b1;
            end else begin
              r_state <= S_RECOVER;
            end
          end else begin
            r_dodge <= 1'b1;
            r_state <= S_RECOVER;
`ifdef PLAYER_COUNTER_EN
            r_armed <= 1'b1;
`endif
          end
        end
        S_RECOVER: begin
          if (r_cnt == '0) begin
            r_lane  <= 2'd1;
            r_state <= S_IDLE;
`ifdef PLAYER_COUNTER_EN
            r_armed <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
`ifdef PLAYER_COUNTER_EN
          // Counter-punch; a lethal one overrides the return to IDLE.
          if (r_armed && w_punch_edge) begin
            r_armed    <= 1'b0;
            r_eh       <= w_eh_dec2;
            r_punch_ok <= 1'b1;
            if (w_eh_dec2 == 4'd0) begin
              r_state <= S_DONE;
              r_go    <= 1'b1;
              r_won   <= 1'b1;
            end
          end
`endif
        end
        S_DONE:  r_go <= 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.player_lane   = r_lane;
  assign bus.player_health = r_ph;
  assign bus.enemy_health  = r_eh;
  assign bus.hit_taken     = r_hit;
  assign bus.dodge_ok      = r_dodge;
  assign bus.punch_landed  = r_punch_ok;
  assign bus.game_over     = r_go;
  assign bus.player_won    = r_won;

endmodule

// File: tb/tb_player_defense_ctrl.sv
module tb_player_defense_ctrl;
  localparam int W = 8;
  localparam int R = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  player_defense_if bus();

  player_defense_ctrl #(.WINDOW_CYCLES(W), .RECOVER_CYCLES(R), .CW(28),
                        .PLAYER_MAX(10), .ENEMY_MAX(15)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // kind is one-hot {punch_landed, dodge_ok, hit_taken}
  typedef struct {
    logic [2:0] kind;
    int         ph;
    int         eh;
    int         at;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [2:0] kind, input int ph, input int eh, input int at);
    exp_t e;
    e.kind = kind; e.ph = ph; e.eh = eh; e.at = at;
    q.push_back(e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.attack_in = 0; bus.enemy_lane = 0; bus.dodge_left = 0;
    bus.dodge_right = 0; bus.block_in = 0; bus.punch = 0;
    q.delete();
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  // Drives a 1-cycle attack; the result pulse is due 9 clocks after the sampling edge.
  task automatic attack(input logic [1:0] lane, input logic [2:0] kind,
                        input int ph, input int eh);
    bus.attack_in = 1'b1; bus.enemy_lane = lane;
    if (kind != 3'b000) push(kind, ph, eh, cyc + W + 2);
    step(1);
    bus.attack_in = 1'b0;
  endtask

  task automatic punch_once(input logic expect_land, input int eh);
    bus.punch = 1'b1;
    if (expect_land) push(3'b100, -1, eh, cyc + 1);
    step(1);
    bus.punch = 1'b0;
    step(1);
  endtask

  task automatic chk_state(input string tag, input int lane, input int ph, input int eh,
                           input int go, input int won);
    chk({tag, "_lane"}, bus.player_lane, lane);
    chk({tag, "_ph"}, bus.player_health, ph);
    chk({tag, "_eh"}, bus.enemy_health, eh);
    chk({tag, "_go"}, bus.game_over, go);
    chk({tag, "_won"}, bus.player_won, won);
  endtask

  // Scoreboard: every result pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (reset_n && (bus.hit_taken || bus.dodge_ok || bus.punch_landed)) begin
      if (q.size() == 0) begin
        chk("unexp_pulse", {bus.punch_landed, bus.dodge_ok, bus.hit_taken}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_kind", {bus.punch_landed, bus.dodge_ok, bus.hit_taken}, e.kind);
        chk("sb_cyc", cyc, e.at);
        if (e.ph >= 0) chk("sb_ph", bus.player_health, e.ph);
        chk("sb_eh", bus.enemy_health, e.eh);
      end
    end
  end

  initial begin
    int eh;
    do_reset();

    // Reset / idle
    step(20);
    @(negedge clock);
    chk_state("idle", 1, 10, 15, 0, 0);
    chk("idle_pulses", {bus.punch_landed, bus.dodge_ok, bus.hit_taken}, 0);

    // Unblocked hit; a punch in the same cycle as the attack is dropped
    step(1);
    bus.punch = 1'b1;
    attack(2'd1, 3'b001, 8, 15);
    bus.punch = 1'b0;
    step(20);
    @(negedge clock);
    chk_state("hit", 1, 8, 15, 0, 0);

    // Dodge right during WINDUP
    do_reset();
    attack(2'd0, 3'b010, 10, 15);
    bus.dodge_right = 1'b1;
    step(2);
    bus.dodge_right = 1'b0;
    @(negedge clock);
    chk("dodge_lane", bus.player_lane, 2);
    step(20);
    @(negedge clock);
    chk_state("dodge_after", 1, 10, 15, 0, 0);

    // Blocked hit; second attack during WINDUP ignored
    do_reset();
    bus.block_in = 1'b1;
    attack(2'd1, 3'b001, 9, 15);
    step(2);
    attack(2'd1, 3'b000, 0, 0);
    step(20);
    bus.block_in = 1'b0;
    @(negedge clock);
    chk_state("block", 1, 9, 15, 0, 0);

    // Lane 3 attack ignored; punch outside lane 1 dropped; dodge saturates at 0
    do_reset();
    attack(2'd3, 3'b000, 0, 0);
    step(15);
    bus.dodge_left = 1'b1; step(1); bus.dodge_left = 1'b0; step(1);
    bus.dodge_left = 1'b1; step(1); bus.dodge_left = 1'b0; step(1);
    @(negedge clock);
    chk("sat_lane0", bus.player_lane, 0);
    step(1);
    punch_once(1'b0, 0);
    step(2);
    @(negedge clock);
    chk_state("lane3_punch0", 0, 10, 15, 0, 0);

    // 15 punches -> enemy dead; further inputs ignored
    do_reset();
    eh = 15;
    for (int i = 0; i < 15; i++) begin
      eh--;
      punch_once(1'b1, eh);
    end
    @(negedge clock);
    chk_state("won", 1, 10, 0, 1, 1);
    step(1);
    attack(2'd1, 3'b000, 0, 0);
    punch_once(1'b0, 0);
    bus.dodge_right = 1'b1; step(2); bus.dodge_right = 1'b0;
    step(20);
    @(negedge clock);
    chk_state("won_hold", 1, 10, 0, 1, 1);

    // Five unblocked hits -> player dead
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      attack(2'd1, 3'b001, 10 - 2 * i, 15);
      step(18);
    end
    @(negedge clock);
    chk_state("lost", 1, 0, 15, 1, 0);

    // Reset mid-WINDUP
    do_reset();
    bus.dodge_right = 1'b1;
    attack(2'd1, 3'b000, 0, 0);
    step(3);
    reset_n = 1'b0;
    #2;
    chk_state("midrst", 1, 10, 15, 0, 0);
    chk("midrst_pulses", {bus.punch_landed, bus.dodge_ok, bus.hit_taken}, 0);
    bus.dodge_right = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(15);
    @(negedge clock);
    chk_state("midrst_after", 1, 10, 15, 0, 0);

    // Counter-punch during RECOVER (dropped in the default build)
    do_reset();
    attack(2'd0, 3'b010, 10, 15);   // dodge_ok seen after sampling edge + 9
    bus.dodge_left = 1'b1;          // 1 -> 0 is still a dodge vs lane 0? no: move right
    bus.dodge_left = 1'b0;
    bus.dodge_right = 1'b1;
    step(2);
    bus.dodge_right = 1'b0;
    step(W);                        // now one clock past the RESOLVE edge: in RECOVER
`ifdef PLAYER_COUNTER_EN
    punch_once(1'b1, 13);
    punch_once(1'b0, 0);
    eh = 13;
`else
    punch_once(1'b0, 0);
    punch_once(1'b0, 0);
    eh = 15;
`endif
    step(10);
    @(negedge clock);
    chk_state("counter", 1, 10, eh, 0, 0);

    chk("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
